// File: rtl/pattern_serializer_pkg.sv
// pattern_serializer shared types
// FSM state encoding and bench default pattern
package seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_e;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/pattern_serializer_if.sv
// pattern_serializer load/stream bundle
// master drives loads, slave is the serializer
interface pattern_serializer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   import seq_pkg::*;

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_pattern;
   logic [CNT_W-1:0] load_repeat;
   logic             abort;
   logic             out;
   logic             out_valid;
   logic             frame_start;
   logic             done;
   logic             busy;

   modport master (
      output load_valid,
      output load_pattern,
      output load_repeat,
      output abort,
      input  load_ready,
      input  out,
      input  out_valid,
      input  frame_start,
      input  done,
      input  busy
   );

   modport slave (
      input  load_valid,
      input  load_pattern,
      input  load_repeat,
      input  abort,
      output load_ready,
      output out,
      output out_valid,
      output frame_start,
      output done,
      output busy
   );

endinterface

// File: rtl/pattern_serializer_shift_reg.sv
// pattern_shift_reg: parallel-load MSB-out shifter
// zeros fill from the LSB so an emptied register reads 0
module pattern_shift_reg
   import seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // load wins over shift
   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   // shift register storage
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: repeat a pattern MSB-first
// FSM and counters; the shifter MSB is the out flop
module pattern_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8,
   parameter int GAP   = 0
) (
   input logic                clk,
   input logic                nrst,
   pattern_serializer_if.slave bus
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP > 0) ? GAP - 1 : 0);

   state_e           state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             valid_q, valid_d;
   logic             fs_q, fs_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             sr_load;
   logic             sr_shift;
   logic [WIDTH-1:0] sr_data;
   logic             accept;

   assign bus.load_ready  = (state_q == S_IDLE);
   assign accept          = bus.load_valid && (state_q == S_IDLE);
   assign bus.out_valid   = valid_q;
   assign bus.frame_start = fs_q;
   assign bus.done        = done_q;
   assign bus.busy        = busy_q;

   pattern_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk     (clk),
      .nrst    (nrst),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .data_i  (sr_data),
      .msb_o   (bus.out)
   );

   // next state, counters and registered output values
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rep_cnt_d = rep_cnt_q;
      gap_cnt_d = gap_cnt_q;
      hold_d    = hold_q;
      valid_d   = 1'b0;
      fs_d      = 1'b0;
      done_d    = 1'b0;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      sr_data   = hold_q;
      if (bus.abort) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         rep_cnt_d = '0;
         gap_cnt_d = '0;
         sr_load   = 1'b1;
         sr_data   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (bus.load_repeat == '0) begin
                     done_d = 1'b1;
                  end else begin
                     hold_d    = bus.load_pattern;
                     sr_load   = 1'b1;
                     sr_data   = bus.load_pattern;
                     rep_cnt_d = bus.load_repeat;
                     bit_cnt_d = BIT_LAST;
                     valid_d   = 1'b1;
                     fs_d      = 1'b1;
                     state_d   = S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               if (bit_cnt_q != '0) begin
                  sr_shift  = 1'b1;
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  valid_d   = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q - 1'b1;
                  if (rep_cnt_q == CNT_W'(1)) begin
                     state_d  = S_IDLE;
                     done_d   = 1'b1;
                     sr_shift = 1'b1;
                  end else if (GAP == 0) begin
                     sr_load   = 1'b1;
                     bit_cnt_d = BIT_LAST;
                     valid_d   = 1'b1;
                     fs_d      = 1'b1;
                  end else begin
                     state_d   = S_GAP;
                     sr_shift  = 1'b1;
                     gap_cnt_d = '0;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d   = S_SHIFT;
                  gap_cnt_d = '0;
                  sr_load   = 1'b1;
                  bit_cnt_d = BIT_LAST;
                  valid_d   = 1'b1;
                  fs_d      = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   // state, counter and output registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         rep_cnt_q <= '0;
         gap_cnt_q <= '0;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         fs_q      <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rep_cnt_q <= rep_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         hold_q    <= hold_d;
         valid_q   <= valid_d;
         fs_q      <= fs_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

endmodule
